// File: rtl/irq_ctrl_if.sv
// Bus and handshake bundle between the 8-bit core side and irq_ctrl.
// The master side is the core/bus; the slave side is the controller.
interface irq_ctrl_if #(
  parameter int N_IRQ = 4
) ();
  logic [N_IRQ-1:0] src_i;
  logic             we_i;
  logic [1:0]       addr_i;
  logic [7:0]       wdata_i;
  logic [7:0]       rdata_o;
  logic             irq_o;
  logic [7:0]       vector_o;
  logic             ack_i;
  logic             eoi_i;

  modport master (
    output src_i, we_i, addr_i, wdata_i, ack_i, eoi_i,
    input  rdata_o, irq_o, vector_o
  );

  modport slave (
    input  src_i, we_i, addr_i, wdata_i, ack_i, eoi_i,
    output rdata_o, irq_o, vector_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Multi-source latched, maskable, fixed-priority interrupt controller with
// vector output and ack/EOI handshake. Optional nesting: IRQ_CTRL_NEST_EN.
module irq_ctrl #(
  parameter int          N_IRQ    = 4,
  parameter logic [7:0]  VEC_BASE = 8'h10
) (
  input logic        clk_i,
  input logic        rst_i,
  irq_ctrl_if.slave  bus
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_reg, state_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic             irq_reg, irq_next;
  logic [7:0]       vector_reg, vector_next;
  logic [N_IRQ-1:0] pend_reg, pend_next;
  logic [N_IRQ-1:0] mask_reg, mask_next;
  logic [N_IRQ-1:0] trig_reg, trig_next;
  logic [N_IRQ-1:0] active_reg, active_next;
  logic [N_IRQ-1:0] prev_reg;

  logic [N_IRQ-1:0] wdata_n;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] pend_en;
  logic [N_IRQ-1:0] id_onehot;
  logic [ID_W-1:0]  cand_idle;
  logic [7:0]       rdata;

`ifdef IRQ_CTRL_NEST_EN
  localparam int DEPTH_W = $clog2(N_IRQ + 1);
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic [ID_W-1:0]    stack_reg [N_IRQ];
  logic [ID_W-1:0]    stack_next [N_IRQ];
  logic [N_IRQ-1:0]   below;
  logic [ID_W-1:0]    cand_nest;
`endif

  function automatic logic [ID_W-1:0] lowest(input logic [N_IRQ-1:0] v);
    lowest = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest = ID_W'(i);
    end
  endfunction

  assign wdata_n   = N_IRQ'(bus.wdata_i);
  assign rise      = bus.src_i & ~prev_reg;
  assign w1c       = (bus.we_i && bus.addr_i == 2'd0) ? wdata_n : '0;
  assign mask_next = (bus.we_i && bus.addr_i == 2'd1) ? wdata_n : mask_reg;
  assign trig_next = (bus.we_i && bus.addr_i == 2'd3) ? wdata_n : trig_reg;
  assign id_onehot = N_IRQ'(1) << id_reg;
  assign ack_clr   = (state_reg == REQ && bus.ack_i) ? id_onehot : '0;
  assign pend_en   = pend_reg & mask_reg;
  assign cand_idle = lowest(pend_en);

  // Edge channels latch rises (a same-cycle rise beats any clear);
  // level channels simply track the source one cycle late.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_chan
      assign pend_next[gi] = trig_reg[gi] ? bus.src_i[gi]
                           : (rise[gi] | (pend_reg[gi] & ~(w1c[gi] | ack_clr[gi])));
    end
  endgenerate

`ifdef IRQ_CTRL_NEST_EN
  assign below     = (N_IRQ'(1) << id_reg) - N_IRQ'(1);
  assign cand_nest = lowest(pend_en & below);
`endif

  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    irq_next    = irq_reg;
    vector_next = vector_reg;
    active_next = active_reg;
`ifdef IRQ_CTRL_NEST_EN
    depth_next  = depth_reg;
    stack_next  = stack_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|pend_en) begin
          id_next     = cand_idle;
          irq_next    = 1'b1;
          vector_next = VEC_BASE + 8'(cand_idle);
          state_next  = REQ;
        end
      end
      REQ: begin
        if (bus.ack_i) begin
          irq_next    = 1'b0;
          active_next = active_reg | id_onehot;
          state_next  = SERVICE;
        end else if (!(|(pend_next & mask_next & id_onehot))) begin
          irq_next = 1'b0;
`ifdef IRQ_CTRL_NEST_EN
          // A retracted nested request falls back to the interrupted level.
          if (depth_reg != '0) begin
            id_next    = stack_reg[ID_W'(depth_reg - DEPTH_W'(1))];
            depth_next = depth_reg - DEPTH_W'(1);
            state_next = SERVICE;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      SERVICE: begin
        if (bus.eoi_i) begin
          active_next = active_reg & ~id_onehot;
`ifdef IRQ_CTRL_NEST_EN
          if (depth_reg != '0) begin
            id_next    = stack_reg[ID_W'(depth_reg - DEPTH_W'(1))];
            depth_next = depth_reg - DEPTH_W'(1);
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
`ifdef IRQ_CTRL_NEST_EN
        else if (|(pend_en & below)) begin
          stack_next[ID_W'(depth_reg)] = id_reg;
          depth_next  = depth_reg + DEPTH_W'(1);
          id_next     = cand_nest;
          irq_next    = 1'b1;
          vector_next = VEC_BASE + 8'(cand_nest);
          state_next  = REQ;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      id_reg     <= '0;
      irq_reg    <= 1'b0;
      vector_reg <= 8'h00;
      pend_reg   <= '0;
      mask_reg   <= '0;
      trig_reg   <= '0;
      active_reg <= '0;
      prev_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      id_reg     <= id_next;
      irq_reg    <= irq_next;
      vector_reg <= vector_next;
      pend_reg   <= pend_next;
      mask_reg   <= mask_next;
      trig_reg   <= trig_next;
      active_reg <= active_next;
      prev_reg   <= bus.src_i;
    end
  end

`ifdef IRQ_CTRL_NEST_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      depth_reg <= '0;
      for (int i = 0; i < N_IRQ; i++) stack_reg[i] <= '0;
    end else begin
      depth_reg <= depth_next;
      stack_reg <= stack_next;
    end
  end
`endif

  always_comb begin
    rdata = 8'h00;
    case (bus.addr_i)
      2'd0: rdata = 8'(pend_reg);
      2'd1: rdata = 8'(mask_reg);
      2'd2: rdata = 8'(active_reg);
      2'd3: rdata = 8'(trig_reg);
      default: rdata = 8'h00;
    endcase
  end

  assign bus.rdata_o  = rdata;
  assign bus.irq_o    = irq_reg;
  assign bus.vector_o = vector_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a request/stack reference model checked every
// cycle, plus hand-computed literal expectations along the way.
module tb_irq_ctrl;
  localparam int         N   = 4;
  localparam logic [7:0] VB  = 8'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  irq_ctrl_if #(.N_IRQ(N)) bus ();

  irq_ctrl #(.N_IRQ(N), .VEC_BASE(VB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending/mask/trig words, the outstanding request (-1 = none)
  // and the list of ids currently in service (ACTIVE is derived from it).
  int m_pend = 0, m_mask = 0, m_trig = 0, m_prev = 0, m_req = -1;
  int m_stack[$];

  function automatic int m_active();
    int a = 0;
    foreach (m_stack[k]) a |= (1 << m_stack[k]);
    return a;
  endfunction

  function automatic int m_lowest(input int v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int src, nm, nt, w1c, ackc, np, mp;
    src = int'(bus.src_i);
    if (rst) begin
      m_pend = 0; m_mask = 0; m_trig = 0; m_prev = 0; m_req = -1;
      m_stack.delete();
      return;
    end
    nm = m_mask; nt = m_trig; w1c = 0;
    if (bus.we_i) begin
      case (bus.addr_i)
        2'd0: w1c = int'(bus.wdata_i) & 'hF;
        2'd1: nm  = int'(bus.wdata_i) & 'hF;
        2'd3: nt  = int'(bus.wdata_i) & 'hF;
        default: ;
      endcase
    end
    ackc = (m_req >= 0 && bus.ack_i) ? (1 << m_req) : 0;
    np = 0;
    for (int i = 0; i < N; i++) begin
      if (m_trig[i]) begin
        if (src[i]) np |= (1 << i);
      end else if ((src[i] && !m_prev[i]) || (m_pend[i] && !w1c[i] && !ackc[i])) begin
        np |= (1 << i);
      end
    end
    mp = m_pend & m_mask;
    if (m_req >= 0) begin
      if (bus.ack_i) begin
        m_stack.push_back(m_req);
        m_req = -1;
      end else if (((np & nm) & (1 << m_req)) == 0) begin
        m_req = -1;
      end
    end else if (m_stack.size() == 0) begin
      if (mp != 0) m_req = m_lowest(mp);
    end else if (bus.eoi_i) begin
      void'(m_stack.pop_back());
    end
`ifdef IRQ_CTRL_NEST_EN
    else if ((mp & ((1 << m_stack[$]) - 1)) != 0) begin
      m_req = m_lowest(mp & ((1 << m_stack[$]) - 1));
    end
`endif
    m_pend = np; m_mask = nm; m_trig = nt; m_prev = src;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic [7:0] exp_rd;
      case (bus.addr_i)
        2'd0: exp_rd = 8'(m_pend);
        2'd1: exp_rd = 8'(m_mask);
        2'd2: exp_rd = 8'(m_active());
        default: exp_rd = 8'(m_trig);
      endcase
      chk("model_irq", 8'(bus.irq_o), 8'(m_req >= 0));
      if (m_req >= 0) chk("model_vector", bus.vector_o, VB + 8'(m_req));
      chk("model_rdata", bus.rdata_o, exp_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
    step();
    bus.we_i = 1'b0;
    $display("wr addr=%0d data=%02h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    bus.addr_i = a;
    look();
    chk(name, bus.rdata_o, exp);
    $display("rd addr=%0d data=%02h (%s)", a, bus.rdata_o, name);
    step();
  endtask

  task automatic irq_is(input logic exp, input string name);
    look();
    chk(name, 8'(bus.irq_o), 8'(exp));
    step();
  endtask

  task automatic req_is(input logic [7:0] vec, input string name);
    look();
    chk({name, "_irq"}, 8'(bus.irq_o), 8'h01);
    chk({name, "_vec"}, bus.vector_o, vec);
    $display("req vector=%02h (%s)", bus.vector_o, name);
    step();
  endtask

  task automatic pulse_ack();
    bus.ack_i = 1'b1; step(); bus.ack_i = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi_i = 1'b1; step(); bus.eoi_i = 1'b0;
  endtask

  initial begin
    bus.src_i = '0; bus.we_i = 1'b0; bus.addr_i = 2'd0; bus.wdata_i = 8'h00;
    bus.ack_i = 1'b0; bus.eoi_i = 1'b0;

    // Reset then idle
    rst = 1'b1; step(); step(); rst = 1'b0;
    cmp_en = 1'b1;
    look(); chk("rst_irq", 8'(bus.irq_o), 8'h00); chk("rst_vector", bus.vector_o, 8'h00); step();
    rd(2'd0, 8'h00, "rst_pend"); rd(2'd1, 8'h00, "rst_mask");
    rd(2'd2, 8'h00, "rst_active"); rd(2'd3, 8'h00, "rst_trig");

    // Single edge on source 2
    wr(2'd1, 8'h04);
    bus.addr_i = 2'd0; bus.src_i = 4'b0100; step(); bus.src_i = '0;
    look(); chk("edge_pend", bus.rdata_o, 8'h04); chk("edge_irq_n1", 8'(bus.irq_o), 8'h00); step();
    req_is(8'h12, "edge_req");
    pulse_ack();
    irq_is(1'b0, "edge_ack_irq");
    rd(2'd2, 8'h04, "edge_active"); rd(2'd0, 8'h00, "edge_pend_clr");
    pulse_eoi();
    rd(2'd2, 8'h00, "edge_eoi_active");

    // Priority: sources 3 and 1 together
    wr(2'd1, 8'h0F);
    bus.src_i = 4'b1010; step(); bus.src_i = '0; step();
    req_is(8'h11, "prio_first");
    pulse_ack();
    pulse_eoi();
    irq_is(1'b0, "prio_gap");
    req_is(8'h13, "prio_second");
    pulse_ack(); pulse_eoi();

    // Masked sources never request
    wr(2'd1, 8'h00);
    bus.src_i = 4'b1010; step(); bus.src_i = '0; step();
    irq_is(1'b0, "masked_irq");
    rd(2'd0, 8'h0A, "masked_pend");
    wr(2'd0, 8'h0F);
    rd(2'd0, 8'h00, "w1c_all");

    // Retract by W1C, then set-wins, then ack over retract
    wr(2'd1, 8'h01);
    bus.src_i = 4'b0001; step(); bus.src_i = '0; step();
    req_is(8'h10, "retract_req");
    wr(2'd0, 8'h01);
    irq_is(1'b0, "retract_irq");
    bus.src_i = 4'b0001; bus.we_i = 1'b1; bus.addr_i = 2'd0; bus.wdata_i = 8'h01;
    step(); bus.src_i = '0; bus.we_i = 1'b0;
    rd(2'd0, 8'h01, "set_wins");
    req_is(8'h10, "set_wins_req");
    bus.ack_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 2'd0; bus.wdata_i = 8'h01;
    step(); bus.ack_i = 1'b0; bus.we_i = 1'b0;
    rd(2'd2, 8'h01, "ack_over_retract");
    pulse_eoi();

    // Level channel on source 1
    wr(2'd3, 8'h02); wr(2'd1, 8'h02);
    bus.src_i = 4'b0010; step(); step();
    req_is(8'h11, "level_req");
    pulse_ack();
    rd(2'd2, 8'h02, "level_active");
    pulse_eoi(); step();
    req_is(8'h11, "level_rereq");
    pulse_ack();
    bus.src_i = '0; step(); step();
    pulse_eoi(); step(); step();
    irq_is(1'b0, "level_no_rereq");
    wr(2'd3, 8'h00);

    // Reset in SERVICE, then stray handshakes
    wr(2'd1, 8'h04);
    bus.src_i = 4'b0100; step(); bus.src_i = '0; step(); step();
    pulse_ack();
    rd(2'd2, 8'h04, "pre_rst_active");
    rst = 1'b1; step(); rst = 1'b0;
    irq_is(1'b0, "mid_rst_irq");
    rd(2'd2, 8'h00, "mid_rst_active"); rd(2'd1, 8'h00, "mid_rst_mask");
    wr(2'd1, 8'h02);
    bus.ack_i = 1'b1; bus.eoi_i = 1'b1; step(); bus.ack_i = 1'b0; bus.eoi_i = 1'b0;
    irq_is(1'b0, "stray_irq");
    rd(2'd1, 8'h02, "stray_mask"); rd(2'd2, 8'h00, "stray_active"); rd(2'd0, 8'h00, "stray_pend");

    // Higher-priority source arriving while id 3 is in service
    wr(2'd1, 8'h0F);
    bus.src_i = 4'b1000; step(); bus.src_i = '0; step();
    req_is(8'h13, "svc3_req");
    pulse_ack();
    bus.src_i = 4'b0001; step(); bus.src_i = '0; step();
`ifdef IRQ_CTRL_NEST_EN
    req_is(8'h10, "nest_req");
    pulse_ack();
    rd(2'd2, 8'h09, "nest_active");
    pulse_eoi();
    rd(2'd2, 8'h08, "nest_eoi1");
    irq_is(1'b0, "nest_eoi1_irq");
    pulse_eoi();
    rd(2'd2, 8'h00, "nest_eoi2");
    irq_is(1'b0, "nest_idle_irq");
`else
    irq_is(1'b0, "no_preempt");
    rd(2'd2, 8'h08, "no_preempt_active");
    pulse_eoi(); step();
    req_is(8'h10, "after_eoi_req");
    pulse_ack(); pulse_eoi();
    rd(2'd2, 8'h00, "final_active");
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
